load_scoreboard: RTL
====================

Name: load_scoreboard

Overview:
- Issue-stage hazard controller for the 4-slot VLIW bundle (slot order ixu1, ixu2, lsu, branch).
- The WB-to-EX forwarding path covers ALU results and LSU non-load results. Load data is never forwarded, so every consumer of a load result must wait until the load has written the register file.
- This block tracks outstanding loads per architectural register and stalls the ID bundle on RAW/WAW hazards against pending loads.
- It also enforces a cap on outstanding loads and flags completion protocol errors.

Parameters:
- MAX_LOADS, 4, maximum number of simultaneously outstanding loads (1..15).
- CNT_W, 4, width of the outstanding-load counter; must satisfy 2**CNT_W > MAX_LOADS.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- id_valid  input  1  ID bundle present (at least one slot is not a nop).
- id_rs1  input  20  rs1 per slot, packed {branch, lsu, ixu2, ixu1}, 5 bits each.
- id_rs2  input  20  rs2 per slot, same packing.
- id_rs1_used  input  4  slot reads rs1 (0 for nop or unused operand).
- id_rs2_used  input  4  slot reads rs2.
- id_rd  input  15  rd for {lsu, ixu2, ixu1}.
- id_rd_we  input  3  slot writes rd, packed {lsu, ixu2, ixu1}.
- id_lsu_is_load  input  1  lsu slot is a load.
- ex_flush  input  1  kill the ID bundle this cycle (branch redirect).
- lsu_ld_done  input  1  a load is writing the register file this cycle.
- lsu_ld_rd  input  5  destination of the completing load.
- id_ready  output  1  bundle may issue (combinational).
- id_issue  output  1  equals id_valid & id_ready & ~ex_flush.
- busy_vec  output  32  registered pending-load bit per register; bit 0 is always 0.
- ld_outstanding  output  CNT_W  registered count of pending loads.
- sb_err  output  1  sticky protocol error.

Behaviour:
- Reset (asynchronous, rst=1): busy_vec=0, ld_outstanding=0, sb_err=0. While rst is high, id_ready=0 and id_issue=0.
- State is busy[31:0] plus the counter. Register x0 never becomes busy.
- RAW stall: any slot s with id_rsN_used[s]=1 and busy[id_rsN[s]]=1.
- WAW stall: any slot with id_rd_we=1, rd!=0 and busy[rd]=1.
- Capacity stall: id_lsu_is_load & id_rd_we[lsu] & lsu rd!=0 & (ld_outstanding==MAX_LOADS).
- id_ready = ~(RAW | WAW | capacity). It is evaluated only against registered state. There is no same-cycle bypass of lsu_ld_done, so a consumer issues at the earliest one cycle after the done cycle.
- On id_issue, if the issuing bundle contains a load with rd!=0: set busy[rd] at the next edge and increment the counter.
- On lsu_ld_done with busy[lsu_ld_rd]=1: clear the bit at the next edge and decrement the counter.
- Simultaneous set and clear on different registers: both apply; counter net change is 0.
- Same-register set and clear in one cycle cannot occur, because WAW blocks the issue.
- lsu_ld_done with lsu_ld_rd=0: ignored; not an error (a load to x0 is never tracked).
- lsu_ld_done with rd!=0 and busy[rd]=0: sb_err sets and holds until reset. busy and the counter are unchanged.
- ex_flush: forces id_issue=0 and causes no state update from the ID bundle. Pending loads are retained and complete normally.
- id_valid=0: id_ready is still computed; no issue occurs.
- Intra-bundle dependencies are not checked; the compiler guarantees none exist.
- Counter never wraps: increment only when below MAX_LOADS, decrement only when above 0. A would-be underflow is impossible given the busy check.

Decomposition:
- Shared package vliw_pkg holds:
  - NUM_SLOTS=4;
  - slot index constants SLOT_IXU1=0, SLOT_IXU2=1, SLOT_LSU=2, SLOT_BR=3;
  - typedef reg_idx_t (logic [4:0]).
- One natural sub-module, hazard_check: the combinational busy-lookup and compare of the 8 source operands and 3 destinations against busy_vec, producing raw and waw.
- Sequential state stays in load_scoreboard.

Test Plan:
- Reset mid-operation: issue loads to x5 and x6, assert rst -> busy_vec=0, ld_outstanding=0, sb_err=0 immediately; a bundle reading x5 then issues in the next cycle after rst falls.
- RAW: issue load x7 at cycle 0, then an ixu1 bundle reading rs1=x7 -> id_ready=0 until lsu_ld_done rd=7 at cycle 4. The bundle issues at cycle 5, not 4.
- WAW / x0: pending load x9, then an ixu2 bundle writing rd=x9 -> stall. A bundle writing x0, and a load to x0, never stall and never set busy_vec[0].
- Capacity with MAX_LOADS=4: four loads to x1..x4 give ld_outstanding=4. A fifth load stalls, including in a cycle with lsu_ld_done rd=1. It issues on the following cycle and the count stays 4.
- Flush: a bundle with load x10 and ex_flush=1 -> id_issue=0 and busy_vec[10] stays 0. An existing pending load x11 still clears on its done.
- Error: lsu_ld_done rd=12 with busy[12]=0 -> sb_err=1 next cycle and stays 1; ld_outstanding is unchanged.

Source files
------------

// File: rtl/vliw_pkg.sv
// Shared VLIW issue-stage definitions.
// Slot order inside packed per-slot buses is {branch, lsu, ixu2, ixu1},
// i.e. ixu1 occupies the least significant field.
package vliw_pkg;

   localparam int NUM_SLOTS = 4;

   localparam int SLOT_IXU1 = 0;
   localparam int SLOT_IXU2 = 1;
   localparam int SLOT_LSU  = 2;
   localparam int SLOT_BR   = 3;

   typedef logic [4:0] reg_idx_t;

endpackage

// File: rtl/hazard_check.sv
// Combinational hazard lookup of an ID bundle against the pending-load set.
// Ports:
//   busy_vec  - pending-load bit per architectural register
//   rs1, rs2  - source registers per slot, packed {branch, lsu, ixu2, ixu1}
//   rs1_used, rs2_used - per-slot operand-read enables
//   rd, rd_we - destinations and write enables, packed {lsu, ixu2, ixu1}
//   raw       - some read operand targets a pending load
//   waw       - some non-x0 destination targets a pending load
module hazard_check
   import vliw_pkg::*;
(
   input  logic [31:0]             busy_vec,
   input  logic [NUM_SLOTS*5-1:0]  rs1,
   input  logic [NUM_SLOTS*5-1:0]  rs2,
   input  logic [NUM_SLOTS-1:0]    rs1_used,
   input  logic [NUM_SLOTS-1:0]    rs2_used,
   input  logic [14:0]             rd,
   input  logic [2:0]              rd_we,
   output logic                    raw,
   output logic                    waw
);

   always_comb begin
      raw = 1'b0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
         if (rs1_used[s] && busy_vec[rs1[s*5 +: 5]]) raw = 1'b1;
         if (rs2_used[s] && busy_vec[rs2[s*5 +: 5]]) raw = 1'b1;
      end
   end

   // Branch slot has no destination, hence only three rd fields.
   always_comb begin
      waw = 1'b0;
      for (int s = 0; s < 3; s++) begin
         if (rd_we[s] && (rd[s*5 +: 5] != 5'd0) && busy_vec[rd[s*5 +: 5]]) waw = 1'b1;
      end
   end

endmodule

// File: rtl/load_scoreboard.sv
// Issue-stage load scoreboard. Load results are never forwarded, so any
// bundle touching a register with a pending load (read or write) is held
// until that load has written the register file. Also caps the number of
// outstanding loads and flags completions for registers that were not pending.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   id_*            - ID bundle description (see hazard_check for packing)
//   ex_flush        - kill the ID bundle this cycle
//   lsu_ld_done/rd  - load completion and its destination
//   id_ready        - bundle may issue (combinational, registered state only)
//   id_issue        - bundle actually issues this cycle
//   busy_vec        - registered pending-load bit per register (bit 0 always 0)
//   ld_outstanding  - registered count of pending loads
//   sb_err          - sticky completion protocol error
module load_scoreboard
   import vliw_pkg::*;
#(
   parameter int unsigned MAX_LOADS = 4,
   parameter int unsigned CNT_W     = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   id_valid,
   input  logic [19:0]            id_rs1,
   input  logic [19:0]            id_rs2,
   input  logic [3:0]             id_rs1_used,
   input  logic [3:0]             id_rs2_used,
   input  logic [14:0]            id_rd,
   input  logic [2:0]             id_rd_we,
   input  logic                   id_lsu_is_load,
   input  logic                   ex_flush,
   input  logic                   lsu_ld_done,
   input  logic [4:0]             lsu_ld_rd,
   output logic                   id_ready,
   output logic                   id_issue,
   output logic [31:0]            busy_vec,
   output logic [CNT_W-1:0]       ld_outstanding,
   output logic                   sb_err
);

   logic [31:0]      busy_q, busy_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   logic     raw, waw, cap;
   reg_idx_t lsu_rd;
   logic     lsu_load;
   logic     set_en, clr_en, bad_done, inc, dec;

   hazard_check u_hazard_check (
      .busy_vec (busy_q),
      .rs1      (id_rs1),
      .rs2      (id_rs2),
      .rs1_used (id_rs1_used),
      .rs2_used (id_rs2_used),
      .rd       (id_rd),
      .rd_we    (id_rd_we),
      .raw      (raw),
      .waw      (waw)
   );

   assign lsu_rd   = id_rd[SLOT_LSU*5 +: 5];
   // Loads to x0 are never tracked and never count against the cap.
   assign lsu_load = id_lsu_is_load && id_rd_we[SLOT_LSU] && (lsu_rd != 5'd0);
   assign cap      = lsu_load && (cnt_q == CNT_W'(MAX_LOADS));

   // No bypass of lsu_ld_done: readiness depends on registered state only.
   assign id_ready = ~rst & ~(raw | waw | cap);
   assign id_issue = id_valid & id_ready & ~ex_flush;

   assign set_en   = id_issue && lsu_load;
   assign clr_en   = lsu_ld_done && (lsu_ld_rd != 5'd0) && busy_q[lsu_ld_rd];
   assign bad_done = lsu_ld_done && (lsu_ld_rd != 5'd0) && !busy_q[lsu_ld_rd];

   assign inc = set_en && (cnt_q < CNT_W'(MAX_LOADS));
   assign dec = clr_en && (cnt_q != '0);

   always_comb begin
      busy_d = busy_q;
      if (clr_en) busy_d[lsu_ld_rd] = 1'b0;
      if (set_en) busy_d[lsu_rd] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_comb begin
      cnt_d = cnt_q;
      if (inc && !dec)      cnt_d = cnt_q + 1'b1;
      else if (dec && !inc) cnt_d = cnt_q - 1'b1;
   end

   assign err_d = err_q | bad_done;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= '0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         err_q  <= err_d;
      end
   end

   assign busy_vec       = busy_q;
   assign ld_outstanding = cnt_q;
   assign sb_err         = err_q;

endmodule
